// File: rtl/obi_mem_pkg.sv
// Shared types and helpers for the OBI subordinate memory.
package obi_mem_pkg;

    localparam int MAX_RD_LATENCY = 4;

    typedef struct packed {
        logic        valid;
        logic        err;
        logic [31:0] rdata;
    } obi_rsp_t;

    // Word offset of a byte address from the base; caller zero-extends narrower buses.
    function automatic logic [63:0] word_index(input logic [63:0] addr, input logic [63:0] base);
        logic [63:0] off;
        off = addr - base;
        return off >> 2;
    endfunction

endpackage

// File: rtl/obi_mem_array.sv
// Single-port NUM_WORDS x 32 array, byte-enabled write and registered read on one edge.
// Latency: read data valid the cycle after en_i; reads return the pre-write word.
// Backpressure: none, accepts an access every cycle.
module obi_mem_array #(
    parameter int NUM_WORDS = 1024,
    parameter int IDX_W     = $clog2(NUM_WORDS)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             we_i,
    input  logic [IDX_W-1:0] idx_i,
    input  logic [31:0]      wdata_i,
    input  logic [3:0]       be_i,
    output logic [31:0]      rdata_o
);

    logic [31:0] mem_q [NUM_WORDS];
    logic [31:0] rdata_q;

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk_i) begin
        if (en_i && we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    // Zero unless a read is being served, so writes and idle cycles carry rdata=0.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (en_i && !we_i) begin
            rdata_q <= mem_q[idx_i];
        end else begin
            rdata_q <= '0;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/obi_sub_mem.sv
// OBI subordinate: req/gnt intake, SRAM-backed byte-enabled access, in-order responses with err.
// Latency: rvalid_o exactly RD_LATENCY cycles after the req/gnt handshake.
// Backpressure: gnt_o low on stall_i or when MAX_OUTSTANDING responses are in flight; responses never stall.
module obi_sub_mem
    import obi_mem_pkg::*;
#(
    parameter int                    DATA_WIDTH      = 32,
    parameter int                    ADDR_WIDTH      = 32,
    parameter int                    NUM_WORDS       = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = '0,
    parameter int                    RD_LATENCY      = 1,
    parameter int                    MAX_OUTSTANDING = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  stall_i,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [3:0]            be_i,
    output logic                  gnt_o,
    output logic                  rvalid_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  err_o
);

    localparam int IDX_W = $clog2(NUM_WORDS);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    if (DATA_WIDTH != 32) begin : g_chk_dw
        $fatal(1, "obi_sub_mem: DATA_WIDTH must be 32");
    end
    if (ADDR_WIDTH < 3 || ADDR_WIDTH > 64) begin : g_chk_aw
        $fatal(1, "obi_sub_mem: ADDR_WIDTH must be 3..64");
    end
    if (NUM_WORDS < 2 || (NUM_WORDS & (NUM_WORDS - 1)) != 0) begin : g_chk_nw
        $fatal(1, "obi_sub_mem: NUM_WORDS must be a power of two >= 2");
    end
    if (BASE_ADDR[1:0] != 2'b00) begin : g_chk_base
        $fatal(1, "obi_sub_mem: BASE_ADDR must be word aligned");
    end
    if (RD_LATENCY < 1 || RD_LATENCY > MAX_RD_LATENCY) begin : g_chk_lat
        $fatal(1, "obi_sub_mem: RD_LATENCY must be 1..4");
    end
    // A limit above RD_LATENCY is tolerated: the fixed pipe never holds more than RD_LATENCY.
    if (MAX_OUTSTANDING < 1) begin : g_chk_out
        $fatal(1, "obi_sub_mem: MAX_OUTSTANDING must be >= 1");
    end

    logic             hs;
    logic             retire;
    logic             in_range;
    logic [63:0]      idx;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             s0_vld_q, s0_err_q;
    logic [31:0]      arr_rdata;
    obi_rsp_t         head;
    obi_rsp_t         rsp_out;

    assign idx      = word_index(64'(addr_i), 64'(BASE_ADDR));
    assign in_range = (addr_i >= BASE_ADDR) && (idx < 64'(NUM_WORDS));

    assign retire = rsp_out.valid;
    assign gnt_o  = req_i & ~stall_i & ~rst_i & ((cnt_q < CNT_W'(MAX_OUTSTANDING)) | retire);
    assign hs     = req_i & gnt_o;

    always_comb begin
        cnt_d = cnt_q;
        if (hs && !retire) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!hs && retire) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q    <= '0;
            s0_vld_q <= 1'b0;
            s0_err_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            s0_vld_q <= hs;
            s0_err_q <= hs & ~in_range;
        end
    end

    obi_mem_array #(
        .NUM_WORDS (NUM_WORDS),
        .IDX_W     (IDX_W)
    ) u_array (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .en_i    (hs & in_range),
        .we_i    (we_i),
        .idx_i   (idx[IDX_W-1:0]),
        .wdata_i (wdata_i),
        .be_i    (be_i),
        .rdata_o (arr_rdata)
    );

    // First pipe stage: handshake flags plus the array's registered read word.
    always_comb begin
        head       = '0;
        head.valid = s0_vld_q;
        head.err   = s0_err_q;
        head.rdata = arr_rdata;
    end

    if (RD_LATENCY == 1) begin : g_lat1
        assign rsp_out = head;
    end else begin : g_latn
        obi_rsp_t [RD_LATENCY-2:0] dly_q;

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                dly_q <= '0;
            end else begin
                dly_q[0] <= head;
                for (int i = 1; i < RD_LATENCY - 1; i++) begin
                    dly_q[i] <= dly_q[i-1];
                end
            end
        end

        assign rsp_out = dly_q[RD_LATENCY-2];
    end

    assign rvalid_o = rsp_out.valid;
    assign err_o    = rsp_out.err;
    assign rdata_o  = rsp_out.rdata;

endmodule

// File: tb/tb_obi_sub_mem.sv
// Randomised scoreboard bench for obi_sub_mem against a word-array reference model.
module tb_obi_sub_mem;

    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam int          NW   = 64;
    localparam int          LAT  = 3;
    localparam int          MAXO = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  be = '0;
    logic        gnt, rvalid, err;
    logic [31:0] rdata;

    always #5 clk = ~clk;

    obi_sub_mem #(
        .DATA_WIDTH      (32),
        .ADDR_WIDTH      (32),
        .NUM_WORDS       (NW),
        .BASE_ADDR       (BASE),
        .RD_LATENCY      (LAT),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .stall_i  (stall),
        .req_i    (req),
        .we_i     (we),
        .addr_i   (addr),
        .wdata_i  (wdata),
        .be_i     (be),
        .gnt_o    (gnt),
        .rvalid_o (rvalid),
        .rdata_o  (rdata),
        .err_o    (err)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    exp_t        exp_q[$];
    int          due_q[$];
    logic [31:0] mem_m [NW];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_fail = 0;
    int          stall_pct = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic bit addr_ok(input logic [31:0] a);
        return (a >= BASE) && (((a - BASE) >> 2) < NW);
    endfunction

    // Reference: grant whenever fewer than MAXO responses are pending or one is due now.
    task automatic drive_cycle(input logic rq, input logic st, input logic w, input logic [31:0] a,
                               input logic [31:0] wd, input logic [3:0] b, output logic granted);
        logic exp_g;
        exp_t e;
        int   i;
        @(negedge clk);
        req = rq; stall = st; we = w; addr = a; wdata = wd; be = b;
        #1;
        while (due_q.size() > 0 && due_q[0] < cyc) void'(due_q.pop_front());
        exp_g = rq && !st && !rst &&
                (due_q.size() < MAXO || (due_q.size() > 0 && due_q[0] == cyc));
        n_cmp++;
        if (gnt !== exp_g) begin
            n_fail++;
            $display("FAIL gnt: cycle %0d got %b expected %b (req=%b stall=%b pending=%0d)",
                     cyc, gnt, exp_g, rq, st, due_q.size());
        end
        granted = rq && (gnt === 1'b1);
        if (granted) begin
            e.due = cyc + LAT;
            e.err = 1'b0;
            e.rdata = '0;
            if (!addr_ok(a)) begin
                e.err = 1'b1;
            end else begin
                i = int'((a - BASE) >> 2);
                if (w) begin
                    for (int k = 0; k < 4; k++)
                        if (b[k]) mem_m[i][8*k +: 8] = wd[8*k +: 8];
                end else begin
                    e.rdata = mem_m[i];
                end
            end
            exp_q.push_back(e);
            due_q.push_back(e.due);
        end
    endtask

    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] b);
        logic g;
        int   n;
        g = 1'b0;
        n = 0;
        while (!g && n < 40) begin
            drive_cycle(1'b1, ($urandom_range(99) < stall_pct), w, a, wd, b, g);
            n++;
        end
        if (!g) begin
            n_cmp++;
            n_fail++;
            $display("FAIL issue_timeout: addr=%h not granted in %0d cycles", a, n);
        end
    endtask

    task automatic idle(input int n);
        logic g;
        for (int k = 0; k < n; k++)
            drive_cycle(1'b0, $urandom_range(1), $urandom_range(1), $urandom, $urandom, 4'($urandom), g);
    endtask

    task automatic reset_check();
        @(negedge clk);
        rst = 1'b1; req = 1'b1; we = 1'b0; addr = BASE; stall = 1'b0;
        #1;
        exp_q.delete();
        due_q.delete();
        n_cmp++;
        if (rvalid !== 1'b0 || err !== 1'b0 || rdata !== 32'h0 || gnt !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: rvalid=%b err=%b rdata=%h gnt=%b, all should be 0",
                     rvalid, err, rdata, gnt);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        req = 1'b0;
    endtask

    // Monitor: every presented response must match the oldest expectation, on its due cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rvalid === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rsp_unexpected: cycle %0d rvalid with err=%b rdata=%h, none expected",
                             cyc, err, rdata);
                end else begin
                    e = exp_q.pop_front();
                    if (e.due != cyc || err !== e.err || rdata !== e.rdata) begin
                        n_fail++;
                        $display("FAIL rsp: cycle %0d got err=%b rdata=%h, expected cycle %0d err=%b rdata=%h",
                                 cyc, err, rdata, e.due, e.err, e.rdata);
                    end
                end
            end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                n_cmp++;
                n_fail++;
                e = exp_q.pop_front();
                $display("FAIL rsp_missing: cycle %0d no rvalid, expected err=%b rdata=%h",
                         cyc, e.err, e.rdata);
            end
        end
    end

    initial begin
        logic [31:0] a;
        int          d;
        reset_check();
        idle(2);

        for (int i = 0; i < NW; i++) issue(1'b1, BASE + 32'(4*i), $urandom, 4'hF);

        // Full write then read-back, partial byte write, empty byte-enable.
        issue(1'b1, BASE + 32'h10, 32'hDEAD_BEEF, 4'hF);
        issue(1'b0, BASE + 32'h10, 32'h0, 4'hF);
        issue(1'b1, BASE + 32'h14, 32'h1122_3344, 4'hF);
        issue(1'b1, BASE + 32'h14, 32'h0000_00AA, 4'b0001);
        issue(1'b0, BASE + 32'h14, 32'h0, 4'hF);
        issue(1'b1, BASE + 32'h14, 32'hFFFF_FFFF, 4'b0000);
        issue(1'b0, BASE + 32'h14, 32'h0, 4'hF);

        // Back-to-back reads with req held: saturation and re-grant on retire.
        for (int i = 0; i < 4; i++) issue(1'b0, BASE + 32'(4*i), 32'h0, 4'hF);

        // Out-of-range on both sides; writes there must not alias into the array.
        issue(1'b0, BASE + 32'(NW*4), 32'h0, 4'hF);
        issue(1'b0, BASE - 32'd4, 32'h0, 4'hF);
        issue(1'b1, BASE + 32'(NW*4), 32'h5A5A_5A5A, 4'hF);
        issue(1'b1, BASE - 32'd4, 32'hA5A5_A5A5, 4'hF);
        issue(1'b0, BASE, 32'h0, 4'hF);
        issue(1'b0, BASE + 32'(4*(NW-1)), 32'h0, 4'hF);

        // Stall with responses in flight.
        issue(1'b0, BASE + 32'h20, 32'h0, 4'hF);
        issue(1'b0, BASE + 32'h24, 32'h0, 4'hF);
        begin
            logic g;
            for (int k = 0; k < 3; k++) drive_cycle(1'b1, 1'b1, 1'b0, BASE + 32'h28, 32'h0, 4'hF, g);
        end
        issue(1'b0, BASE + 32'h28, 32'h0, 4'hF);

        // Reset with two reads in flight; later requests must be granted immediately.
        issue(1'b0, BASE + 32'h30, 32'h0, 4'hF);
        issue(1'b0, BASE + 32'h34, 32'h0, 4'hF);
        reset_check();
        idle(6);
        issue(1'b0, BASE + 32'h30, 32'h0, 4'hF);
        issue(1'b0, BASE + 32'h34, 32'h0, 4'hF);

        stall_pct = 20;
        for (int t = 0; t < 400; t++) begin
            d = ($urandom_range(3) == 0) ? int'($urandom_range(2)) : 0;
            if (d > 0) idle(d);
            case ($urandom_range(9))
                0: a = BASE + 32'(NW*4) + 32'(4*$urandom_range(15));
                1: a = BASE - 32'd4 - 32'(4*$urandom_range(15));
                2: a = 32'hFFFF_FFF0;
                default: a = BASE + 32'(4*$urandom_range(NW-1));
            endcase
            a = a | 32'($urandom_range(3));
            issue($urandom_range(1), a, $urandom, 4'($urandom));
        end

        stall_pct = 0;
        begin
            int n;
            n = 0;
            while (exp_q.size() > 0 && n < 20) begin
                idle(1);
                n++;
            end
        end
        idle(LAT + 2);
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain: %0d responses never arrived", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
